serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder that drives the team's one-bit `fulladder` cell with one bit pair per clock, LSB first.
- Carry is held in a flip-flop between cycles; sum bits are shifted into a result register.
- Used where area matters more than latency. It sits between a valid/ready producer of operand pairs and a valid/ready consumer of results.

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/fulladder.sv | 13 +
 rtl/serial_adder.sv | 91 +++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks: FSM state encoding and default width.
package serial_arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full-adder cell.
module fulladder (
   output logic s,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through a single fulladder, LSB first,
// with valid/ready handshakes on operands and result.
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             fa_s, fa_c;
   logic             accept, last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == LAST_BIT);

   fulladder u_fa (
      .s    (fa_s),
      .cout (fa_c),
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Operands are captured only on an accepted handshake, so idle-bus X never reaches state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         cnt   <= '0;
         carry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               sum   <= {fa_s, sum[WIDTH-1:1]};
               carry <= fa_c;
               cnt   <= cnt + 1'b1;
               if (last) cout <= fa_c;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

   int errors = 0;
   int checks = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair for a single edge (block is assumed idle).
   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
      a = va; b = vb; cin = vc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 'x; b = 'x; cin = 1'bx;
   endtask

   // Count edges until out_valid, bounded.
   task automatic wait_valid(output int cycles, output bit timeout);
      cycles = 0;
      while (!out_valid && cycles < 100) begin
         tick();
         cycles++;
      end
      timeout = !out_valid;
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (sum !== 8'h00)      begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
      checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
   endtask

   task automatic test_basic();
      int cyc; bit to;
      out_ready = 1'b1;
      send(8'h5A, 8'h3C, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy in_ready=%b exp=0", in_ready); end
      wait_valid(cyc, to);
      checks++; if (to || cyc != 8) begin errors++; $display("FAIL basic_latency got=%0d timeout=%0d exp=8", cyc, to); end
      checks++; if (sum !== 8'h96) begin errors++; $display("FAIL basic_sum got=%h exp=96", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", cout); end
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_return in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_wrap();
      int cyc; bit to;
      out_ready = 1'b1;
      send(8'hFF, 8'h01, 1'b0);
      wait_valid(cyc, to);
      checks++; if (to || {cout, sum} !== 9'h100) begin
         errors++; $display("FAIL wrap_ff01 got=%b_%h exp=1_00 timeout=%0d", cout, sum, to);
      end
      tick();
      send(8'hFF, 8'hFF, 1'b1);
      wait_valid(cyc, to);
      checks++; if (to || {cout, sum} !== 9'h1FF) begin
         errors++; $display("FAIL wrap_ffff1 got=%b_%h exp=1_ff timeout=%0d", cout, sum, to);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int cyc; bit to; bit bad;
      out_ready = 1'b0;
      send(8'h12, 8'h34, 1'b1);
      wait_valid(cyc, to);
      checks++; if (to || {cout, sum} !== 9'h047) begin
         errors++; $display("FAIL bp_first got=%b_%h exp=0_47 timeout=%0d", cout, sum, to);
      end
      bad = 0;
      repeat (5) begin
         tick();
         if (out_valid !== 1'b1 || sum !== 8'h47 || cout !== 1'b0 || in_ready !== 1'b0) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL bp_hold got=%b_%h ov=%b exp=0_47 ov=1", cout, sum, out_valid); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_ignore_in_valid();
      int cyc; bit to; bit bad;
      out_ready = 1'b1;
      send(8'h01, 8'h02, 1'b0);
      tick(); tick();
      a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
      bad = 0;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         if (in_ready !== 1'b0) bad = 1;
         tick();
         cyc++;
      end
      checks++; if (bad) begin errors++; $display("FAIL ign_in_ready rose during run exp=0"); end
      checks++; if (!out_valid || {cout, sum} !== 9'h003) begin
         errors++; $display("FAIL ign_sum got=%b_%h ov=%b exp=0_03", cout, sum, out_valid);
      end
      in_valid = 1'b0;
      tick();
      bad = 0;
      repeat (12) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
         tick();
      end
      checks++; if (bad) begin errors++; $display("FAIL ign_captured stray operands produced activity"); end
   endtask

   task automatic test_async_reset();
      int cyc; bit to;
      out_ready = 1'b1;
      send(8'h77, 8'h11, 1'b0);
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h00 || cout !== 1'b0) begin
         errors++; $display("FAIL areset ov=%b ir=%b sum=%h cout=%b exp=0/1/00/0", out_valid, in_ready, sum, cout);
      end
      @(negedge clk) rst = 1'b0;
      tick();
      send(8'h10, 8'h20, 1'b0);
      wait_valid(cyc, to);
      checks++; if (to || cyc != 8 || {cout, sum} !== 9'h030) begin
         errors++; $display("FAIL areset_after got=%b_%h lat=%0d exp=0_30 lat=8", cout, sum, cyc);
      end
      tick();
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   exp_v;
      int           cyc, results, dups;
      bit           got;
      results = 0;
      dups    = 0;
      for (int i = 0; i < 1000; i++) begin
         out_ready = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         exp_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         send(ra, rb, rc);
         got = 0;
         cyc = 0;
         while (!got && cyc < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
               got = 1;
               results++;
               checks++; if ({cout, sum} !== exp_v) begin
                  errors++; $display("FAIL rand_%0d a=%h b=%h c=%b got=%b_%h exp=%h", i, ra, rb, rc, cout, sum, exp_v);
               end
            end
            tick();
            cyc++;
         end
         if (!got) begin
            checks++; errors++; $display("FAIL rand_timeout_%0d no result", i);
         end
         if (out_valid !== 1'b0) dups++;
      end
      out_ready = 1'b1;
      checks++; if (results != 1000 || dups != 0) begin
         errors++; $display("FAIL rand_count results=%0d dups=%0d exp=1000/0", results, dups);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      #12;
      test_reset();
      @(negedge clk) rst = 1'b0;
      tick();
      test_basic();
      test_wrap();
      test_backpressure();
      test_ignore_in_valid();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
